// File: rtl/seq101_pattern_gen_pkg.sv
// seq101_pattern_gen_pkg
// Shared widths, FSM state encoding and the length clamp helper for the
// "101" pattern generator slice.
//   No ports. Imported by the interface, the hit tracker and the top.
package seq101_pattern_gen_pkg;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 4;
  localparam int HIT_W   = 8;
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/seq101_pattern_gen_if.sv
// seq101_pattern_gen_if
// Request/stream bundle between a pattern-generator client and the generator.
//   start, pattern, length, repeat_n : client -> generator
//   w, w_valid, busy, done, hit_count : generator -> client
//   modport master : client side
//   modport slave  : generator side
interface seq101_pattern_gen_if;
  import seq101_pattern_gen_pkg::*;

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic [REP_W-1:0]   repeat_n;
  logic               w;
  logic               w_valid;
  logic               busy;
  logic               done;
  logic [HIT_W-1:0]   hit_count;

  modport master (
    output start, pattern, length, repeat_n,
    input  w, w_valid, busy, done, hit_count
  );

  modport slave (
    input  start, pattern, length, repeat_n,
    output w, w_valid, busy, done, hit_count
  );

endinterface

// File: rtl/seq101_hit_tracker.sv
// seq101_hit_tracker
// Counts overlapping "101" occurrences in a valid-qualified bit stream.
//   clock     : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   clear     : synchronous clear of history and count
//   bit_valid : bit_in carries a stream bit this cycle
//   bit_in    : stream bit
//   count     : saturating occurrence count
module seq101_hit_tracker
  import seq101_pattern_gen_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [HIT_W-1:0] count
);

  // hist[1] is the older bit, hist[0] the newer one
  logic [1:0] hist;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hist  <= 2'b00;
      count <= '0;
    end else if (clear) begin
      hist  <= 2'b00;
      count <= '0;
    end else if (bit_valid) begin
      hist <= {hist[0], bit_in};
      if ((hist == 2'b10) && bit_in && (count != {HIT_W{1'b1}}))
        count <= count + HIT_W'(1);
    end
  end

endmodule

// File: rtl/seq101_pattern_gen.sv
// seq101_pattern_gen
// Serial MSB-first pattern transmitter feeding the "101" detector, with an
// optional back-to-back repeat and a running count of "101" hits emitted.
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : seq101_pattern_gen_if.slave (start/pattern/length/repeat_n in,
//            w/w_valid/busy/done/hit_count out)
//
// state | meaning
// IDLE  | waiting for start; hit_count holds last run's result
// SHIFT | one pattern bit on w per cycle, passes back-to-back
// DONE  | single-cycle done pulse, start ignored
module seq101_pattern_gen
  import seq101_pattern_gen_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  seq101_pattern_gen_if.slave  bus
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               w_q, w_d;
  logic               accept;
  logic [LEN_W-1:0]   eff_len;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   wrap_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [HIT_W-1:0]   hit_count;

  assign eff_len   = clamp_len(bus.length);
  // Top index of the pass; only meaningful when the length is non-zero.
  assign first_idx = IDX_W'(eff_len - LEN_W'(1));
  assign wrap_idx  = IDX_W'(len_q - LEN_W'(1));
  assign next_idx  = idx_q - IDX_W'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    w_d     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          pat_d  = bus.pattern;
          len_d  = eff_len;
          rep_d  = bus.repeat_n;
          pass_d = '0;
          idx_d  = first_idx;
          if (eff_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            w_d     = bus.pattern[first_idx];
          end
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          if (pass_q == rep_q) begin
            state_d = DONE;
          end else begin
            pass_d = pass_q + REP_W'(1);
            idx_d  = wrap_idx;
            w_d    = pat_q[wrap_idx];
          end
        end else begin
          idx_d = next_idx;
          w_d   = pat_q[next_idx];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pat_q  <= '0;
      len_q  <= '0;
      rep_q  <= '0;
      pass_q <= '0;
      idx_q  <= '0;
      w_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      rep_q  <= rep_d;
      pass_q <= pass_d;
      idx_q  <= idx_d;
      w_q    <= w_d;
    end
  end

  // The bit on w during SHIFT enters the history on the following edge, so
  // hit_count is final by the DONE cycle.
  seq101_hit_tracker u_hit_tracker (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (accept),
    .bit_valid (state_q == SHIFT),
    .bit_in    (w_q),
    .count     (hit_count)
  );

  assign bus.w         = w_q;
  assign bus.w_valid   = (state_q == SHIFT);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.hit_count = hit_count;

endmodule

// File: tb/tb_seq101_pattern_gen.sv
module tb_seq101_pattern_gen;

  logic clock = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  bit   exp_bits[$];

  always #5 clock = ~clock;

  seq101_pattern_gen_if u_if ();

  seq101_pattern_gen dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if.slave)
  );

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          rep;
    int          hits;
    bit          noisy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Overlapping "101" count over the first n bits of the expected stream.
  function automatic int hits_upto(input int n);
    int c = 0;
    for (int j = 2; j < n; j++)
      if (exp_bits[j-2] && !exp_bits[j-1] && exp_bits[j]) c++;
    return (c > 255) ? 255 : c;
  endfunction

  // Called just after a falling edge; exp_hits < 0 means use the model.
  task automatic run_txn(input logic [15:0] pat, input int len, input int rep,
                         input int exp_hits, input bit noisy);
    int eff, t, h;
    eff = (len > 16) ? 16 : len;
    exp_bits.delete();
    for (int p = 0; p <= rep; p++)
      for (int b = eff - 1; b >= 0; b--)
        exp_bits.push_back(pat[b]);
    t = exp_bits.size();
    h = (exp_hits < 0) ? hits_upto(t) : exp_hits;
    u_if.pattern  = pat;
    u_if.length   = 5'(len);
    u_if.repeat_n = 4'(rep);
    u_if.start    = 1'b1;
    @(negedge clock);
    u_if.start = 1'b0;
    for (int i = 0; i < t; i++) begin
      chk("w_valid", int'(u_if.w_valid), 1);
      chk("w_bit", int'(u_if.w), int'(exp_bits[i]));
      chk("busy", int'(u_if.busy), 1);
      chk("done_early", int'(u_if.done), 0);
      chk("hit_running", int'(u_if.hit_count), hits_upto(i));
      u_if.pattern  = 16'($urandom);
      u_if.length   = 5'($urandom);
      u_if.repeat_n = 4'($urandom);
      u_if.start    = noisy ? 1'($urandom) : 1'b0;
      @(negedge clock);
    end
    chk("done_pulse", int'(u_if.done), 1);
    chk("busy_in_done", int'(u_if.busy), 0);
    chk("w_valid_in_done", int'(u_if.w_valid), 0);
    chk("w_in_done", int'(u_if.w), 0);
    chk("hit_final", int'(u_if.hit_count), h);
    u_if.start = noisy;
    @(negedge clock);
    chk("done_cleared", int'(u_if.done), 0);
    chk("busy_idle", int'(u_if.busy), 0);
    chk("w_valid_idle", int'(u_if.w_valid), 0);
    chk("hit_hold", int'(u_if.hit_count), h);
    u_if.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0005,  3, 0, 1, 1'b0};
    vecs[1] = '{16'h0015,  5, 0, 2, 1'b0};
    vecs[2] = '{16'h0005,  3, 2, 3, 1'b0};
    vecs[3] = '{16'hFFFF, 20, 0, 0, 1'b1};
    vecs[4] = '{16'h000D,  4, 1, 2, 1'b0};
    vecs[5] = '{16'h0009,  4, 1, 0, 1'b1};
    vecs[6] = '{16'h0002,  2, 2, 2, 1'b0};

    resetn        = 1'b0;
    u_if.start    = 1'b0;
    u_if.pattern  = '0;
    u_if.length   = '0;
    u_if.repeat_n = '0;
    repeat (2) @(negedge clock);
    chk("rst_w", int'(u_if.w), 0);
    chk("rst_w_valid", int'(u_if.w_valid), 0);
    chk("rst_busy", int'(u_if.busy), 0);
    chk("rst_done", int'(u_if.done), 0);
    chk("rst_hit", int'(u_if.hit_count), 0);
    resetn = 1'b1;
    @(negedge clock);

    foreach (vecs[i])
      run_txn(vecs[i].pat, vecs[i].len, vecs[i].rep, vecs[i].hits, vecs[i].noisy);

    // Zero length, start held through DONE, re-accepted from IDLE.
    u_if.pattern  = 16'hFFFF;
    u_if.length   = 5'd0;
    u_if.repeat_n = 4'd3;
    u_if.start    = 1'b1;
    @(negedge clock);
    chk("zl_done", int'(u_if.done), 1);
    chk("zl_w_valid", int'(u_if.w_valid), 0);
    chk("zl_busy", int'(u_if.busy), 0);
    chk("zl_hit_cleared", int'(u_if.hit_count), 0);
    @(negedge clock);
    chk("zl_start_in_done_ignored", int'(u_if.done), 0);
    chk("zl_idle_w_valid", int'(u_if.w_valid), 0);
    @(negedge clock);
    chk("zl_reaccept_done", int'(u_if.done), 1);
    u_if.start = 1'b0;
    @(negedge clock);
    chk("zl_back_idle", int'(u_if.done), 0);

    // Asynchronous reset in the middle of SHIFT.
    u_if.pattern  = 16'h0015;
    u_if.length   = 5'd5;
    u_if.repeat_n = 4'd1;
    u_if.start    = 1'b1;
    @(negedge clock);
    u_if.start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_rst_w", int'(u_if.w), 1);
    chk("pre_rst_hit", int'(u_if.hit_count), 1);
    chk("pre_rst_busy", int'(u_if.busy), 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_w", int'(u_if.w), 0);
    chk("arst_w_valid", int'(u_if.w_valid), 0);
    chk("arst_busy", int'(u_if.busy), 0);
    chk("arst_hit", int'(u_if.hit_count), 0);
    chk("arst_done", int'(u_if.done), 0);
    repeat (2) begin
      @(negedge clock);
      chk("arst_no_done", int'(u_if.done), 0);
    end
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_no_done", int'(u_if.done), 0);
    run_txn(16'h0015, 5, 0, 2, 1'b0);

    // Randomized runs against the stream model.
    for (int n = 0; n < 40; n++) begin
      run_txn(16'($urandom), int'($urandom_range(0, 20)),
              (n % 8 == 7) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
              -1, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
